// File: rtl/fxp_gain_stream.sv
// Per-channel fixed-point gain on an interleaved sample stream.
// Flow: multiply, then round/saturate, then an output FIFO that is read show-ahead.
module fxp_gain_stream #(
  parameter int DATA_W     = 32,
  parameter int FRAC_W     = 16,
  parameter int GAIN_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     out_chan,
  output logic              out_sat,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_chan,
  input  logic [GAIN_W-1:0] cfg_gain,
  output logic [15:0]       sat_count
);

  localparam int PW = DATA_W + GAIN_W;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = DATA_W + CW + 1;

  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);
  localparam logic [GAIN_W-1:0] UNITY =
    {{(GAIN_W - FRAC_W - 1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
  localparam logic signed [PW:0] HALF =
    {{(PW - FRAC_W + 1){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};
  localparam logic signed [PW:0] MAXV =
    {{(PW - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [PW:0] MINV =
    {{(PW - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  // Handshake: a word moves on a port only at a rising edge where valid and
  // ready are both high. in_ready never looks at in_valid, and the out_* bus
  // is held stable while out_valid=1 and out_ready=0.

  logic                     run;
  logic [CW-1:0]            chan_cnt;
  logic signed [GAIN_W-1:0] gain [CHANNELS];

  logic                     s1_valid;
  logic signed [PW-1:0]     s1_prod;
  logic [CW-1:0]            s1_chan;

  logic                     s2_valid;
  logic [DATA_W-1:0]        s2_data;
  logic [CW-1:0]            s2_chan;
  logic                     s2_sat;

  logic [EW-1:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [AW:0]              count;
  logic [15:0]              sat_cnt;

  logic [AW+1:0]            occupancy;
  logic                     in_fire;
  logic                     out_fire;
  logic                     cfg_hit;
  logic signed [PW:0]       rounded;
  logic signed [PW:0]       shifted;
  logic [DATA_W-1:0]        s2_data_next;
  logic                     s2_sat_next;

  // Every accepted sample already owns a FIFO slot, so stage 2 never stalls.
  always_comb begin
    occupancy = (AW+2)'(count) + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
    in_ready  = run && (occupancy < (AW+2)'(FIFO_DEPTH));
    in_fire   = in_valid && in_ready;
    out_valid = (count != '0);
    out_fire  = out_valid && out_ready;
    cfg_hit   = cfg_we && (32'(cfg_chan) < CHANNELS);
  end

  // Round half up, then clip to the sample range.
  always_comb begin
    rounded      = {s1_prod[PW-1], s1_prod} + HALF;
    shifted      = rounded >>> FRAC_W;
    s2_data_next = shifted[DATA_W-1:0];
    s2_sat_next  = 1'b0;
    if (shifted > MAXV) begin
      s2_data_next = MAXV[DATA_W-1:0];
      s2_sat_next  = 1'b1;
    end else if (shifted < MINV) begin
      s2_data_next = MINV[DATA_W-1:0];
      s2_sat_next  = 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    out_chan = '0;
    out_sat  = 1'b0;
    if (out_valid) begin
      out_data = mem[rd_ptr][DATA_W-1:0];
      out_chan = mem[rd_ptr][DATA_W +: CW];
      out_sat  = mem[rd_ptr][EW-1];
    end
  end

  assign sat_count = sat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      run      <= 1'b0;
      chan_cnt <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sat_cnt  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        gain[i] <= UNITY;
      end
    end else begin
      run      <= 1'b1;
      s1_valid <= in_fire;
      s2_valid <= s1_valid;
      if (in_fire) begin
        chan_cnt <= (chan_cnt == LAST_CHAN) ? '0 : chan_cnt + CW'(1);
      end
      // The sample accepted on this edge was multiplied by the old gain.
      if (cfg_hit) begin
        gain[cfg_chan] <= cfg_gain;
      end
      if (s1_valid && s2_sat_next && (sat_cnt != 16'hFFFF)) begin
        sat_cnt <= sat_cnt + 16'd1;
      end
      if (s2_valid) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (out_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({s2_valid, out_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Datapath registers carry no reset; their valid bits gate them.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_prod <= PW'($signed(in_data)) * PW'(gain[chan_cnt]);
      s1_chan <= chan_cnt;
    end
    if (s1_valid) begin
      s2_data <= s2_data_next;
      s2_chan <= s1_chan;
      s2_sat  <= s2_sat_next;
    end
    if (s2_valid) begin
      mem[wr_ptr] <= {s2_sat, s2_chan, s2_data};
    end
  end

endmodule
